// File: rtl/cdb_rr_arbiter_pkg.sv
// Purpose: shared CDB types and default sizing for the arbiter and the CDB_PACKET consumers.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package cdb_rr_arbiter_pkg;

  localparam int CDB_NUM_FU   = 5;
  localparam int CDB_TAG_W    = 5;
  localparam int CDB_XLEN     = 32;
  localparam int CDB_STAT_W   = 32;
  localparam int CDB_FU_IDX_W = $clog2(CDB_NUM_FU);

  // One FU's pending result as seen on the CDB request side.
  typedef struct packed {
    logic                 valid;
    logic [CDB_TAG_W-1:0] rob_tag;
    logic [CDB_XLEN-1:0]  value;
  } CDB_ARB_REQ;

  // Round-robin successor: the FU after the winner gets top priority next.
  function automatic int rr_next(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_rr_arbiter_rr_priority_pick.sv
// Purpose: round-robin pick - rotate req by ptr, fixed-priority encode, rotate back.
// Latency: purely combinational.
// Backpressure: none; reports the winner of the current request vector.
// Ports: req (request vector), ptr (highest-priority index),
//        grant (one-hot winner), grant_idx (winner index), any (some request present).
module rr_priority_pick #(
  parameter int  NUM_FU = 5,
  localparam int IDX_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic [NUM_FU-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_FU-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              any
);

  logic [NUM_FU-1:0] req_rot;
  int                first_j;

  // req_rot[0] is the FU at ptr, req_rot[1] the one after it, and so on.
  always_comb begin
    req_rot = '0;
    for (int j = 0; j < NUM_FU; j++) begin
      req_rot[j] = req[(j + int'(ptr)) % NUM_FU];
    end
  end

  always_comb begin
    first_j = 0;
    any     = 1'b0;
    for (int j = 0; j < NUM_FU; j++) begin
      if (!any && req_rot[j]) begin
        any     = 1'b1;
        first_j = j;
      end
    end
    grant_idx = IDX_W'((first_j + int'(ptr)) % NUM_FU);
    grant     = any ? (NUM_FU'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/cdb_rr_arbiter.sv
// Purpose: round-robin arbiter sharing the single CDB among the ex-stage FUs.
// Latency: ack combinational in the request cycle; cdb_* broadcast registered, 1 cycle later.
// Backpressure: losers keep req asserted until acked; squash/reset suppress all acks.
// Ports: clock, reset (sync, active-high), squash; req/req_tag/req_value per FU;
//        ack (one-hot grant); cdb_valid/cdb_tag/cdb_value/cdb_fu_idx (registered broadcast).
// Option: define CDB_ARB_STATS_EN to add stat_grants/stat_stall/stat_idle saturating counters.
module cdb_rr_arbiter
  import cdb_rr_arbiter_pkg::*;
#(
  parameter int  NUM_FU   = CDB_NUM_FU,
  parameter int  TAG_W    = CDB_TAG_W,
  parameter int  XLEN     = CDB_XLEN,
`ifdef CDB_ARB_STATS_EN
  parameter int  STAT_W   = CDB_STAT_W,
`endif
  localparam int FU_IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    squash,
  input  logic [NUM_FU-1:0]       req,
  input  logic [NUM_FU*TAG_W-1:0] req_tag,
  input  logic [NUM_FU*XLEN-1:0]  req_value,
  output logic [NUM_FU-1:0]       ack,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [XLEN-1:0]         cdb_value,
  output logic [FU_IDX_W-1:0]     cdb_fu_idx
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [NUM_FU*STAT_W-1:0] stat_grants,
  output logic [STAT_W-1:0]        stat_stall,
  output logic [STAT_W-1:0]        stat_idle
`endif
);

  logic [FU_IDX_W-1:0] rr_ptr;
  logic [NUM_FU-1:0]   pick_grant;
  logic [FU_IDX_W-1:0] pick_idx;
  logic                pick_any;
  logic                grant_en;

  rr_priority_pick #(.NUM_FU(NUM_FU)) u_pick (
    .req       (req),
    .ptr       (rr_ptr),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  // A grant only happens when the bus is not being flushed or reset.
  assign grant_en = pick_any && !squash && !reset;
  assign ack      = grant_en ? pick_grant : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr     <= '0;
      cdb_valid  <= 1'b0;
      cdb_tag    <= '0;
      cdb_value  <= '0;
      cdb_fu_idx <= '0;
    end else begin
      // Valid clears on squash or idle; payload holds its last value.
      cdb_valid <= grant_en;
      if (grant_en) begin
        cdb_tag    <= req_tag[int'(pick_idx)*TAG_W +: TAG_W];
        cdb_value  <= req_value[int'(pick_idx)*XLEN +: XLEN];
        cdb_fu_idx <= pick_idx;
        rr_ptr     <= FU_IDX_W'(rr_next(int'(pick_idx), NUM_FU));
      end
    end
  end

`ifdef CDB_ARB_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_grants <= '0;
      stat_stall  <= '0;
      stat_idle   <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (ack[i] && (stat_grants[i*STAT_W +: STAT_W] != '1)) begin
          stat_grants[i*STAT_W +: STAT_W] <= stat_grants[i*STAT_W +: STAT_W] + STAT_W'(1);
        end
      end
      // A stall cycle is one where at least one requester had to lose.
      if (!squash && ($countones(req) >= 2) && (stat_stall != '1)) begin
        stat_stall <= stat_stall + STAT_W'(1);
      end
      if ((req == '0) && (stat_idle != '1)) begin
        stat_idle <= stat_idle + STAT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
module tb_cdb_rr_arbiter;
  localparam int N  = 5;
  localparam int TW = 5;
  localparam int XW = 32;
  localparam int IW = 3;
`ifdef CDB_ARB_STATS_EN
  localparam int SW = 32;
`endif

  logic            clock = 1'b0;
  logic            reset;
  logic            squash;
  logic [N-1:0]    req;
  logic [N*TW-1:0] req_tag;
  logic [N*XW-1:0] req_value;
  logic [N-1:0]    ack;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [XW-1:0]   cdb_value;
  logic [IW-1:0]   cdb_fu_idx;
`ifdef CDB_ARB_STATS_EN
  logic [N*SW-1:0] stat_grants;
  logic [SW-1:0]   stat_stall;
  logic [SW-1:0]   stat_idle;
`endif

  int checks = 0;
  int failures = 0;

  cdb_rr_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .squash     (squash),
    .req        (req),
    .req_tag    (req_tag),
    .req_value  (req_value),
    .ack        (ack),
    .cdb_valid  (cdb_valid),
    .cdb_tag    (cdb_tag),
    .cdb_value  (cdb_value),
    .cdb_fu_idx (cdb_fu_idx)
`ifdef CDB_ARB_STATS_EN
    ,
    .stat_grants(stat_grants),
    .stat_stall (stat_stall),
    .stat_idle  (stat_idle)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: scan from ptr with wrap, first requester wins; -1 if none.
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Behavioural model state, advanced once per rising edge.
  int           m_ptr;
  logic         m_valid;
  logic [TW-1:0] m_tag;
  logic [XW-1:0] m_val;
  int           m_idx;
  int           m_grants [N];
  int           m_stall;
  int           m_idle;
  bit           started = 0;

  always @(posedge clock) begin
    int g;
    if (reset) begin
      m_ptr = 0; m_valid = 0; m_tag = '0; m_val = '0; m_idx = 0;
      for (int i = 0; i < N; i++) m_grants[i] = 0;
      m_stall = 0; m_idle = 0;
    end else begin
      g = squash ? -1 : rr_pick(req, m_ptr);
      if (req == '0) m_idle++;
      if (!squash && $countones(req) >= 2) m_stall++;
      m_valid = (g >= 0);
      if (g >= 0) begin
        m_grants[g]++;
        m_tag = req_tag[g*TW +: TW];
        m_val = req_value[g*XW +: XW];
        m_idx = g;
        m_ptr = (g + 1) % N;
      end
    end
    started = 1;
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clock) begin
    if (started) begin
      int g;
      logic [N-1:0] exp_ack;
      g = (reset || squash) ? -1 : rr_pick(req, m_ptr);
      exp_ack = (g < 0) ? '0 : N'(1 << g);
      chk("m_ack", 64'(ack), 64'(exp_ack));
      chk("m_ack_onehot0", 64'($onehot0(ack)), 64'(1));
      chk("m_ack_subset_req", 64'(ack & ~req), 64'(0));
      chk("m_cdb_valid", 64'(cdb_valid), 64'(m_valid));
      chk("m_cdb_tag", 64'(cdb_tag), 64'(m_tag));
      chk("m_cdb_value", 64'(cdb_value), 64'(m_val));
      chk("m_cdb_fu_idx", 64'(cdb_fu_idx), 64'(m_idx));
`ifdef CDB_ARB_STATS_EN
      for (int i = 0; i < N; i++) chk("m_stat_grants", 64'(stat_grants[i*SW +: SW]), 64'(m_grants[i]));
      chk("m_stat_stall", 64'(stat_stall), 64'(m_stall));
      chk("m_stat_idle", 64'(stat_idle), 64'(m_idle));
`endif
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_fu(input int i, input logic [TW-1:0] t, input logic [XW-1:0] v);
    req_tag[i*TW +: TW]   = t;
    req_value[i*XW +: XW] = v;
  endtask

  typedef struct {
    logic [N-1:0] r;
    logic         sq;
  } vec_t;

  vec_t tbl [12];

  initial begin
    reset = 1'b1; squash = 1'b0; req = 5'b11111;
    req_tag = '0; req_value = '0;

    // Reset holds acks low even with every FU requesting.
    step();
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("rst_ack", 64'(ack), 64'(0));
      chk("rst_cdb_valid", 64'(cdb_valid), 64'(0));
      step();
    end
    reset = 1'b0; req = '0;
    @(negedge clock);
    chk("post_rst_cdb_valid", 64'(cdb_valid), 64'(0));
    step();

    // Single requester: ack now, broadcast next cycle.
    set_fu(2, 5'd7, 32'hDEAD_BEEF);
    req = 5'b00100;
    @(negedge clock);
    chk("single_ack", 64'(ack), 64'(5'b00100));
    step();
    req = '0;
    @(negedge clock);
    chk("single_valid", 64'(cdb_valid), 64'(1));
    chk("single_tag", 64'(cdb_tag), 64'(7));
    chk("single_value", 64'(cdb_value), 64'(32'hDEAD_BEEF));
    chk("single_idx", 64'(cdb_fu_idx), 64'(2));
    step();

    // Mid-stream reset, then all requesting: strict rotation from FU0.
    for (int i = 0; i < N; i++) set_fu(i, TW'(10 + i), XW'(32'h1000 + i));
    reset = 1'b1; req = 5'b11111;
    @(negedge clock);
    chk("midrst_ack", 64'(ack), 64'(0));
    step();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      logic [N-1:0] e;
      e = 5'b00001 << (c % N);
      @(negedge clock);
      chk("rotate_ack", 64'(ack), 64'(e));
      step();
    end
    req = '0;

    // Wrap-around: move pointer to 3, then FU0, FU1, then lone FU4.
    req = 5'b00100;
    @(negedge clock);
    chk("wrap_setup_ack", 64'(ack), 64'(5'b00100));
    step();
    req = 5'b00011;
    @(negedge clock);
    chk("wrap_ack0", 64'(ack), 64'(5'b00001));
    step();
    @(negedge clock);
    chk("wrap_ack1", 64'(ack), 64'(5'b00010));
    step();
    req = 5'b10000;
    @(negedge clock);
    chk("wrap_ack4", 64'(ack), 64'(5'b10000));
    step();

    // Squash: no ack, visible broadcast not retracted, valid clears next cycle.
    squash = 1'b1; req = 5'b01000;
    @(negedge clock);
    chk("squash_ack", 64'(ack), 64'(0));
    chk("squash_vis_valid", 64'(cdb_valid), 64'(1));
    chk("squash_vis_idx", 64'(cdb_fu_idx), 64'(4));
    step();
    squash = 1'b0;
    @(negedge clock);
    chk("post_squash_valid", 64'(cdb_valid), 64'(0));
    chk("post_squash_ack", 64'(ack), 64'(5'b01000));
    step();
    req = '0;
    @(negedge clock);
    chk("post_squash_idx", 64'(cdb_fu_idx), 64'(3));
    chk("post_squash_tag", 64'(cdb_tag), 64'(13));
    step();

    // Mixed vectors checked by the model only.
    tbl[0]  = '{5'b10101, 1'b0}; tbl[1]  = '{5'b10101, 1'b0};
    tbl[2]  = '{5'b10101, 1'b0}; tbl[3]  = '{5'b01010, 1'b1};
    tbl[4]  = '{5'b01010, 1'b0}; tbl[5]  = '{5'b11000, 1'b0};
    tbl[6]  = '{5'b00001, 1'b0}; tbl[7]  = '{5'b00001, 1'b0};
    tbl[8]  = '{5'b00000, 1'b0}; tbl[9]  = '{5'b11111, 1'b1};
    tbl[10] = '{5'b11111, 1'b0}; tbl[11] = '{5'b00110, 1'b0};
    for (int v = 0; v < 12; v++) begin
      req = tbl[v].r; squash = tbl[v].sq;
      set_fu(v % N, TW'(v + 20), XW'($urandom));
      step();
    end
    req = '0; squash = 1'b0;
    step();

`ifdef CDB_ARB_STATS_EN
    // Counters after a fresh reset: 4 contended cycles, 2 idle ones.
    reset = 1'b1;
    step();
    reset = 1'b0; req = 5'b00011;
    for (int c = 0; c < 4; c++) step();
    req = '0;
    for (int c = 0; c < 2; c++) step();
    @(negedge clock);
    chk("stat_grants0", 64'(stat_grants[0*SW +: SW]), 64'(2));
    chk("stat_grants1", 64'(stat_grants[1*SW +: SW]), 64'(2));
    chk("stat_stall", 64'(stat_stall), 64'(4));
    chk("stat_idle", 64'(stat_idle), 64'(2));
    step();
`endif

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
